// File: rtl/rx_frame_pkg.sv
// Shared constants and state encoding for the UART receive framing stage.
package rx_frame_pkg;

  localparam logic [7:0] HDR_BYTE = 8'h55;
  localparam int         MAX_LEN  = 16;
  localparam int         BUF_AW   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

endpackage

// File: rtl/frame_buf_module.sv
// Payload buffer: single-port RAM with synchronous write and registered read.
module frame_buf_module
  import rx_frame_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = BUF_AW
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // No reset on the array or read register so the tools can map it to block RAM.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/rx_frame_parser_module.sv
// Header hunt, length-prefixed payload capture and additive checksum check for
// bytes from the UART receiver; a good frame is held until acknowledged.
module rx_frame_parser_module
  import rx_frame_pkg::*;
#(
  parameter int TIMEOUT_CYC = 52080,
  parameter int MAX_LEN     = rx_frame_pkg::MAX_LEN
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       RX_Done_Sig,
  input  logic [7:0] RX_Data,
  input  logic [3:0] Rd_Addr,
  output logic [7:0] Rd_Data,
  output logic [4:0] Frame_Len,
  output logic       Frame_Valid,
  input  logic       Frame_Ack,
  output logic       Chk_Err_Sig,
  output logic       Fmt_Err_Sig,
  output logic       Timeout_Sig,
  output logic       Overrun_Sig
);

  localparam int         CNT_W     = $clog2(TIMEOUT_CYC);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t           state_reg, state_next;
  logic [4:0]       len_reg, len_next;
  logic [4:0]       idx_reg, idx_next;
  logic [4:0]       idx_inc;
  logic [7:0]       sum_reg, sum_next;
  logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             chk_err_reg, chk_err_next;
  logic             fmt_err_reg, fmt_err_next;
  logic             timeout_reg, timeout_next;
  logic             overrun_reg, overrun_next;
  logic             buf_we;
  logic [3:0]       buf_addr;
  logic [7:0]       buf_q;

  assign idx_inc = 5'(idx_reg + 5'd1);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg   <= ST_IDLE;
      len_reg     <= '0;
      idx_reg     <= '0;
      sum_reg     <= '0;
      tmo_cnt_reg <= '0;
      chk_err_reg <= 1'b0;
      fmt_err_reg <= 1'b0;
      timeout_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      idx_reg     <= idx_next;
      sum_reg     <= sum_next;
      tmo_cnt_reg <= tmo_cnt_next;
      chk_err_reg <= chk_err_next;
      fmt_err_reg <= fmt_err_next;
      timeout_reg <= timeout_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    idx_next     = idx_reg;
    sum_next     = sum_reg;
    tmo_cnt_next = '0;
    chk_err_next = 1'b0;
    fmt_err_next = 1'b0;
    timeout_next = 1'b0;
    overrun_next = overrun_reg;
    buf_we       = 1'b0;

    // Inter-byte watchdog; a byte arriving on the terminal cycle wins.
    if (state_reg == ST_LEN || state_reg == ST_PAYLOAD || state_reg == ST_CHECK) begin
      if (RX_Done_Sig) begin
        tmo_cnt_next = '0;
      end else if (tmo_cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
        timeout_next = 1'b1;
        state_next   = ST_IDLE;
      end else begin
        tmo_cnt_next = tmo_cnt_reg + 1'b1;
      end
    end

    case (state_reg)
      ST_IDLE: begin
        if (RX_Done_Sig && RX_Data == HDR_BYTE) begin
          state_next = ST_LEN;
        end
      end
      ST_LEN: begin
        if (RX_Done_Sig) begin
          if (RX_Data == 8'd0 || RX_Data > MAX_LEN_B) begin
            fmt_err_next = 1'b1;
            state_next   = ST_IDLE;
          end else begin
            len_next   = RX_Data[4:0];
            sum_next   = RX_Data;
            idx_next   = '0;
            state_next = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (RX_Done_Sig) begin
          buf_we   = 1'b1;
          sum_next = sum_reg + RX_Data;
          idx_next = idx_inc;
          if (idx_inc == len_reg) begin
            state_next = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (RX_Done_Sig) begin
          if (RX_Data == sum_reg) begin
            state_next = ST_HOLD;
          end else begin
            chk_err_next = 1'b1;
            state_next   = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        // A header coinciding with the ack starts the next frame without loss.
        if (Frame_Ack) begin
          overrun_next = 1'b0;
          state_next   = (RX_Done_Sig && RX_Data == HDR_BYTE) ? ST_LEN : ST_IDLE;
        end else if (RX_Done_Sig) begin
          overrun_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The single RAM port is borrowed for writes only while a payload byte lands.
  assign buf_addr = buf_we ? idx_reg[3:0] : Rd_Addr;

  frame_buf_module #(
    .DEPTH(16),
    .AW   (4)
  ) u_frame_buf (
    .CLK  (CLK),
    .we   (buf_we),
    .addr (buf_addr),
    .wdata(RX_Data),
    .rdata(buf_q)
  );

  assign Frame_Valid = (state_reg == ST_HOLD);
  assign Frame_Len   = len_reg;
  assign Rd_Data     = Frame_Valid ? buf_q : 8'h00;
  assign Chk_Err_Sig = chk_err_reg;
  assign Fmt_Err_Sig = fmt_err_reg;
  assign Timeout_Sig = timeout_reg;
  assign Overrun_Sig = overrun_reg;

endmodule

// File: tb/tb_rx_frame_parser_module.sv
// Directed and randomized frame stimulus for rx_frame_parser_module, checked
// against checksum/length arithmetic computed in the bench.
module tb_rx_frame_parser_module;

  typedef logic [7:0] bq_t[$];

  localparam int TMO = 40;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       RX_Done_Sig = 1'b0;
  logic [7:0] RX_Data = 8'h00;
  logic [3:0] Rd_Addr = 4'h0;
  logic       Frame_Ack = 1'b0;
  logic [7:0] Rd_Data;
  logic [4:0] Frame_Len;
  logic       Frame_Valid;
  logic       Chk_Err_Sig;
  logic       Fmt_Err_Sig;
  logic       Timeout_Sig;
  logic       Overrun_Sig;

  int vectors = 0;
  int miscompares = 0;
  int n_chk = 0, n_fmt = 0, n_tmo = 0;
  int b_chk, b_fmt, b_tmo;

  always #5 CLK = ~CLK;

  rx_frame_parser_module #(
    .TIMEOUT_CYC(TMO),
    .MAX_LEN    (16)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .RX_Done_Sig(RX_Done_Sig),
    .RX_Data    (RX_Data),
    .Rd_Addr    (Rd_Addr),
    .Rd_Data    (Rd_Data),
    .Frame_Len  (Frame_Len),
    .Frame_Valid(Frame_Valid),
    .Frame_Ack  (Frame_Ack),
    .Chk_Err_Sig(Chk_Err_Sig),
    .Fmt_Err_Sig(Fmt_Err_Sig),
    .Timeout_Sig(Timeout_Sig),
    .Overrun_Sig(Overrun_Sig)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse counting; each cycle high counts once, so a stretched pulse shows up.
  always @(negedge CLK) begin
    if (RSTn) begin
      if (Chk_Err_Sig) n_chk++;
      if (Fmt_Err_Sig) n_fmt++;
      if (Timeout_Sig) n_tmo++;
      if (Chk_Err_Sig || Fmt_Err_Sig || Timeout_Sig)
        check("one_err_per_cycle", int'(Chk_Err_Sig) + int'(Fmt_Err_Sig) + int'(Timeout_Sig), 1);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    RX_Data = b;
    RX_Done_Sig = 1'b1;
    @(posedge CLK);
    #1;
    RX_Done_Sig = 1'b0;
  endtask

  task automatic send_frame(input bq_t fr, input int maxgap);
    foreach (fr[i]) begin
      send(fr[i]);
      if (i != fr.size() - 1) idle($urandom_range(0, maxgap));
    end
  endtask

  function automatic logic [7:0] frame_chk(input bq_t pl);
    int s = pl.size();
    foreach (pl[i]) s += int'(pl[i]);
    return 8'(s % 256);
  endfunction

  task automatic snap();
    b_chk = n_chk;
    b_fmt = n_fmt;
    b_tmo = n_tmo;
  endtask

  task automatic deltas(input string tag, input int e_chk, input int e_fmt, input int e_tmo);
    idle(1);
    check({tag, "_chk_pulses"}, n_chk - b_chk, e_chk);
    check({tag, "_fmt_pulses"}, n_fmt - b_fmt, e_fmt);
    check({tag, "_tmo_pulses"}, n_tmo - b_tmo, e_tmo);
  endtask

  task automatic read_chk(input string tag, input int addr, input logic [7:0] exp);
    Rd_Addr = 4'(addr);
    @(posedge CLK);
    #1;
    check(tag, Rd_Data, exp);
  endtask

  task automatic ack_chk(input string tag);
    Frame_Ack = 1'b1;
    @(posedge CLK);
    #1;
    Frame_Ack = 1'b0;
    check({tag, "_valid_after_ack"}, Frame_Valid, 1'b0);
  endtask

  initial begin
    bq_t pl, fr;
    logic [7:0] c;
    int seen;

    #12;
    check("reset_valid", Frame_Valid, 1'b0);
    check("reset_len", Frame_Len, 5'd0);
    check("reset_rd", Rd_Data, 8'h00);
    check("reset_errs", {Chk_Err_Sig, Fmt_Err_Sig, Timeout_Sig, Overrun_Sig}, 4'h0);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;

    // Good three-byte frame, back to back.
    pl = '{8'h11, 8'h22, 8'h33};
    fr = {8'h55, 8'h03};
    fr = {fr, pl, frame_chk(pl)};
    snap();
    send_frame(fr, 0);
    check("good3_valid", Frame_Valid, 1'b1);
    check("good3_len", Frame_Len, 5'd3);
    deltas("good3", 0, 0, 0);
    foreach (pl[i]) read_chk($sformatf("good3_rd%0d", i), i, pl[i]);
    ack_chk("good3");

    // 0x79 is not (3 + 0x11 + 0x22 + 0x33) mod 256 = 0x69, so this is a bad checksum.
    snap();
    send_frame('{8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79}, 0);
    check("chk79_valid", Frame_Valid, 1'b0);
    deltas("chk79", 1, 0, 0);

    snap();
    send_frame('{8'h55, 8'h02, 8'h10, 8'h20, 8'h31}, 1);
    check("chk31_valid", Frame_Valid, 1'b0);
    deltas("chk31", 1, 0, 0);
    pl = '{8'hA0, 8'h0B};
    fr = {8'h55, 8'h02};
    fr = {fr, pl, frame_chk(pl)};
    send_frame(fr, 0);
    check("after_chk_valid", Frame_Valid, 1'b1);
    read_chk("after_chk_rd1", 1, 8'h0B);
    ack_chk("after_chk");

    // Illegal lengths, each followed by a header hunt.
    snap();
    send_frame('{8'h55, 8'h00}, 0);
    deltas("len00", 0, 1, 0);
    snap();
    send_frame('{8'h55, 8'h11}, 0);
    deltas("len11", 0, 1, 0);
    snap();
    send_frame('{8'h01, 8'h07, 8'h08}, 0);
    check("hunt_valid", Frame_Valid, 1'b0);
    deltas("hunt", 0, 0, 0);

    // Timeout: pulse appears TMO cycles after the last accepted byte.
    snap();
    send_frame('{8'h55, 8'h04, 8'hAA}, 0);
    seen = -1;
    for (int k = 1; k <= TMO + 10; k++) begin
      idle(1);
      if (Timeout_Sig && seen < 0) seen = k;
    end
    check("tmo_latency", seen, TMO);
    check("tmo_pulses", n_tmo - b_tmo, 1);
    snap();
    send_frame('{8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAE}, 0);
    idle(TMO + 5);
    check("tmo_headerless_valid", Frame_Valid, 1'b0);
    check("tmo_headerless_pulses", (n_chk - b_chk) + (n_fmt - b_fmt) + (n_tmo - b_tmo), 0);

    // Overrun while held, then ack together with a fresh header.
    pl = '{8'h5A, 8'hC3};
    fr = {8'h55, 8'h02};
    fr = {fr, pl, frame_chk(pl)};
    send_frame(fr, 2);
    check("ovr_valid", Frame_Valid, 1'b1);
    check("ovr_before", Overrun_Sig, 1'b0);
    send(8'hA5);
    check("ovr_set", Overrun_Sig, 1'b1);
    check("ovr_still_valid", Frame_Valid, 1'b1);
    check("ovr_len", Frame_Len, 5'd2);
    read_chk("ovr_rd0", 0, 8'h5A);
    read_chk("ovr_rd1", 1, 8'hC3);
    Frame_Ack = 1'b1;
    send(8'h55);
    Frame_Ack = 1'b0;
    check("ovr_cleared", Overrun_Sig, 1'b0);
    check("ovr_ack_valid", Frame_Valid, 1'b0);
    send_frame('{8'h01, 8'h7E, 8'h7F}, 0);
    check("ack_hdr_valid", Frame_Valid, 1'b1);
    check("ack_hdr_len", Frame_Len, 5'd1);
    read_chk("ack_hdr_rd0", 0, 8'h7E);
    ack_chk("ack_hdr");

    // Reset in the middle of a payload.
    snap();
    send_frame('{8'h55, 8'h03, 8'h01}, 0);
    #1 RSTn = 1'b0;
    #1;
    check("rst_mid_valid", Frame_Valid, 1'b0);
    check("rst_mid_len", Frame_Len, 5'd0);
    check("rst_mid_rd", Rd_Data, 8'h00);
    check("rst_mid_flags", {Chk_Err_Sig, Fmt_Err_Sig, Timeout_Sig, Overrun_Sig}, 4'h0);
    idle(2);
    #3 RSTn = 1'b1;
    @(posedge CLK);
    #1;
    send_frame('{8'h55, 8'h01, 8'hFF, 8'h00}, 0);
    check("post_rst_valid", Frame_Valid, 1'b1);
    check("post_rst_len", Frame_Len, 5'd1);
    deltas("post_rst", 0, 0, 0);
    read_chk("post_rst_rd0", 0, 8'hFF);
    ack_chk("post_rst");

    // Randomized frames: good, corrupted checksum, or illegal length.
    for (int n = 0; n < 30; n++) begin
      int kind, len;
      logic [7:0] j;
      kind = $urandom_range(0, 2);
      len  = $urandom_range(1, 16);
      pl = {};
      fr = {};
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      for (int i = $urandom_range(0, 3); i > 0; i--) begin
        j = 8'($urandom);
        fr.push_back((j == 8'h55) ? 8'h54 : j);
      end
      fr.push_back(8'h55);
      if (kind == 2) begin
        fr.push_back(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(17, 255)));
      end else begin
        fr.push_back(8'(len));
        fr = {fr, pl};
        c = frame_chk(pl);
        if (kind == 1) c = c ^ 8'($urandom_range(1, 255));
        fr.push_back(c);
      end
      snap();
      send_frame(fr, 3);
      check($sformatf("rnd%0d_valid", n), Frame_Valid, (kind == 0) ? 1'b1 : 1'b0);
      if (kind == 0) begin
        check($sformatf("rnd%0d_len", n), Frame_Len, 5'(len));
        deltas($sformatf("rnd%0d", n), 0, 0, 0);
        foreach (pl[i]) read_chk($sformatf("rnd%0d_rd%0d", n, i), i, pl[i]);
        ack_chk($sformatf("rnd%0d", n));
      end else begin
        deltas($sformatf("rnd%0d", n), (kind == 1) ? 1 : 0, (kind == 2) ? 1 : 0, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
